// File: rtl/seg_arb_pkg.sv
// Shared types and constants for the 7-segment display arbiter.
package seg_arb_pkg;

    localparam int DISP_W = 16;

    // Value shown on disp_num before any source has ever been granted.
    localparam logic [DISP_W-1:0] BLANK_PATTERN = 16'h0000;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HOLD = 2'd1,
        S_SHOW = 2'd2
    } state_t;

    // Width of a counter that must reach n; never narrower than one bit.
    function automatic int cnt_w(input longint n);
        return (n > 0) ? $clog2(n + 1) : 1;
    endfunction

endpackage

// File: rtl/seg_display_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module rr_pick #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] ptr,
    output logic                     grant_valid,
    output logic [$clog2(N_REQ)-1:0] grant_idx
);

    localparam int IDX_W = $clog2(N_REQ);

    function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] p, input int off);
        int s;
        s = int'(p) + off;
        if (s >= N_REQ) s = s - N_REQ;
        return IDX_W'(s);
    endfunction

    // NOTE: every output gets a default before the loop so no latch is inferred.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        // Scan from the farthest offset down so the closest set bit wins last.
        for (int off = N_REQ - 1; off >= 0; off--) begin
            if (req[wrap_idx(ptr, off)]) begin
                grant_valid = 1'b1;
                grant_idx   = wrap_idx(ptr, off);
            end
        end
    end

endmodule

// File: rtl/seg_display_arbiter.sv
// Round-robin sharing of one 4-digit 7-segment display among N_REQ requesters,
// with a minimum dwell after each grant and optional blanking when left idle.
module seg_display_arbiter
    import seg_arb_pkg::*;
#(
    parameter int N_REQ        = 4,
    parameter int HOLD_CYCLES  = 100_000_000,
    parameter int BLANK_CYCLES = 1_000_000_000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [DISP_W*N_REQ-1:0]   req_data,
    output logic [N_REQ-1:0]          req_ack,
    output logic [DISP_W-1:0]         disp_num,
    output logic                      disp_blank,
    output logic [$clog2(N_REQ)-1:0]  disp_src,
    output logic                      busy
);

    localparam int SRC_W  = $clog2(N_REQ);
    localparam int HOLD_W = cnt_w(HOLD_CYCLES);
    localparam int IDLE_W = cnt_w(BLANK_CYCLES);

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(BLANK_CYCLES - 1);
    localparam logic [SRC_W-1:0]  SRC_LAST  = SRC_W'(N_REQ - 1);
    localparam bit                BLANK_EN  = (BLANK_CYCLES != 0);

    state_t             state, state_next;
    logic [SRC_W-1:0]   ptr;
    logic [HOLD_W-1:0]  hold_cnt;
    logic [IDLE_W-1:0]  idle_cnt;

    logic               pick_valid;
    logic [SRC_W-1:0]   pick_idx;
    logic [N_REQ-1:0]   open_mask;
    logic               grant;
    logic               hold_done;
    logic               idle_done;
    logic               refresh;
    logic [SRC_W-1:0]   ptr_next;
    logic [DISP_W-1:0]  pick_data;
    logic [DISP_W-1:0]  owner_data;

    // A source whose ack is still on the wire is never re-granted in that cycle.
    assign open_mask = req_valid & ~req_ack;

    rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req         (open_mask),
        .ptr         (ptr),
        .grant_valid (pick_valid),
        .grant_idx   (pick_idx)
    );

    assign grant      = (state == S_IDLE || state == S_SHOW) && pick_valid;
    assign hold_done  = (hold_cnt == HOLD_LAST);
    assign idle_done  = BLANK_EN && (idle_cnt == IDLE_LAST);
    assign refresh    = req_valid[disp_src] && !req_ack[disp_src];
    assign ptr_next   = (pick_idx == SRC_LAST) ? '0 : pick_idx + 1'b1;
    assign pick_data  = req_data[int'(pick_idx) * DISP_W +: DISP_W];
    assign owner_data = req_data[int'(disp_src) * DISP_W +: DISP_W];

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE:  if (pick_valid) state_next = S_HOLD;
            S_HOLD:  if (hold_done)  state_next = S_SHOW;
            S_SHOW: begin
                if (pick_valid)     state_next = S_HOLD;
                else if (idle_done) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state == S_HOLD);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            disp_num   <= BLANK_PATTERN;
            disp_blank <= 1'b1;
            disp_src   <= '0;
            req_ack    <= '0;
            ptr        <= '0;
            hold_cnt   <= '0;
            idle_cnt   <= '0;
        end else begin
            req_ack <= '0;
            if (grant) begin
                disp_num          <= pick_data;
                disp_src          <= pick_idx;
                req_ack[pick_idx] <= 1'b1;
                disp_blank        <= 1'b0;
                ptr               <= ptr_next;
                hold_cnt          <= '0;
            end else if (state == S_HOLD) begin
                hold_cnt <= hold_cnt + 1'b1;
                if (hold_done) idle_cnt <= '0;
                // The owner may update its value mid-dwell without extending it.
                if (refresh) begin
                    disp_num          <= owner_data;
                    req_ack[disp_src] <= 1'b1;
                end
            end else if (state == S_SHOW) begin
                if (idle_done) disp_blank <= 1'b1;
                else           idle_cnt   <= idle_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Directed bench for seg_display_arbiter with N_REQ=4, HOLD_CYCLES=8, BLANK_CYCLES=20.
module tb_seg_display_arbiter;

    localparam int N     = 4;
    localparam int HOLD  = 8;
    localparam int BLANK = 20;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [15:0] data [4];
    logic [63:0] req_data;
    logic [3:0]  req_ack;
    logic [15:0] disp_num;
    logic        disp_blank;
    logic [1:0]  disp_src;
    logic        busy;

    int total = 0;
    int bad   = 0;

    assign req_data = {data[3], data[2], data[1], data[0]};

    seg_display_arbiter #(
        .N_REQ        (N),
        .HOLD_CYCLES  (HOLD),
        .BLANK_CYCLES (BLANK)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ack    (req_ack),
        .disp_num   (disp_num),
        .disp_blank (disp_blank),
        .disp_src   (disp_src),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    // Advance one clock; outputs are sampled 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_show();
        for (int i = 0; i < 20 && busy; i++) tick();
    endtask

    task automatic do_reset();
        req_valid = '0;
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        total++; if (disp_num !== 16'h0000) begin bad++; $display("FAIL reset_num: got %h want 0000", disp_num); end
        total++; if (disp_blank !== 1'b1) begin bad++; $display("FAIL reset_blank: got %b want 1", disp_blank); end
        total++; if (disp_src !== 2'd0) begin bad++; $display("FAIL reset_src: got %0d want 0", disp_src); end
        total++; if (req_ack !== 4'b0000) begin bad++; $display("FAIL reset_ack: got %b want 0000", req_ack); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    endtask

    task automatic test_grant_hold();
        int n;
        data[2]   = 16'h1234;
        req_valid = 4'b0100;
        tick();
        total++; if (req_ack !== 4'b0100) begin bad++; $display("FAIL grant_ack: got %b want 0100", req_ack); end
        total++; if (disp_num !== 16'h1234) begin bad++; $display("FAIL grant_num: got %h want 1234", disp_num); end
        total++; if (disp_src !== 2'd2) begin bad++; $display("FAIL grant_src: got %0d want 2", disp_src); end
        total++; if (disp_blank !== 1'b0) begin bad++; $display("FAIL grant_blank: got %b want 0", disp_blank); end
        req_valid = '0;
        n = 1;
        tick();
        total++; if (req_ack !== 4'b0000) begin bad++; $display("FAIL ack_one_cycle: got %b want 0000", req_ack); end
        for (int i = 0; i < 20 && busy; i++) begin
            n++;
            tick();
        end
        total++; if (n !== HOLD) begin bad++; $display("FAIL busy_len: got %0d want %0d", n, HOLD); end
    endtask

    task automatic test_pending_in_hold();
        logic seen;
        data[3]   = 16'h3333;
        req_valid = 4'b1000;
        tick();
        total++; if (req_ack !== 4'b1000) begin bad++; $display("FAIL pend_first_ack: got %b want 1000", req_ack); end
        req_valid = 4'b0001;
        data[0]   = 16'hAAAA;
        seen = 1'b0;
        for (int i = 0; i < HOLD - 1; i++) begin
            tick();
            if (req_ack !== 4'b0000) seen = 1'b1;
        end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL pend_ack_in_hold: got %b want 0", seen); end
        tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL pend_show_busy: got %b want 0", busy); end
        total++; if (disp_num !== 16'h3333) begin bad++; $display("FAIL pend_show_num: got %h want 3333", disp_num); end
        tick();
        total++; if (req_ack !== 4'b0001) begin bad++; $display("FAIL pend_grant_ack: got %b want 0001", req_ack); end
        total++; if (disp_num !== 16'hAAAA) begin bad++; $display("FAIL pend_grant_num: got %h want AAAA", disp_num); end
        req_valid = '0;
        wait_show();
    endtask

    task automatic test_round_robin();
        int g;
        int last;
        logic [3:0] one_hot;
        do_reset();
        for (int i = 0; i < N; i++) data[i] = 16'hC000 + 16'(i);
        req_valid = 4'hF;
        g = 0;
        last = 0;
        for (int c = 1; c <= 60 && g < 5; c++) begin
            tick();
            if (req_ack !== 4'b0000) begin
                one_hot = 4'b0001 << (g % N);
                total++; if (req_ack !== one_hot) begin bad++; $display("FAIL rr_ack%0d: got %b want %b", g, req_ack, one_hot); end
                total++; if (disp_num !== 16'hC000 + 16'(g % N)) begin bad++; $display("FAIL rr_num%0d: got %h want %h", g, disp_num, 16'hC000 + 16'(g % N)); end
                if (g > 0) begin
                    total++; if (c - last !== HOLD + 1) begin bad++; $display("FAIL rr_gap%0d: got %0d want %0d", g, c - last, HOLD + 1); end
                end else begin
                    total++; if (c !== 1) begin bad++; $display("FAIL rr_first_cycle: got %0d want 1", c); end
                end
                last = c;
                g++;
                req_valid = ~req_ack;
            end
        end
        total++; if (g !== 5) begin bad++; $display("FAIL rr_count: got %0d want 5", g); end
        req_valid = '0;
        wait_show();
    endtask

    task automatic test_owner_refresh();
        int t;
        data[1]   = 16'h1111;
        req_valid = 4'b0010;
        tick();
        total++; if (disp_num !== 16'h1111) begin bad++; $display("FAIL ref_grant_num: got %h want 1111", disp_num); end
        req_valid = '0;
        repeat (3) tick();
        data[1]   = 16'h00FF;
        req_valid = 4'b0010;
        tick();
        total++; if (req_ack !== 4'b0010) begin bad++; $display("FAIL ref_ack: got %b want 0010", req_ack); end
        total++; if (disp_num !== 16'h00FF) begin bad++; $display("FAIL ref_num: got %h want 00FF", disp_num); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL ref_busy: got %b want 1", busy); end
        req_valid = '0;
        t = 4;
        for (int i = 0; i < 20 && busy; i++) begin
            tick();
            t++;
        end
        total++; if (t !== HOLD) begin bad++; $display("FAIL ref_show_at: got %0d want %0d", t, HOLD); end
    endtask

    task automatic test_blank();
        int t;
        data[2]   = 16'h5A5A;
        req_valid = 4'b0100;
        tick();
        total++; if (disp_src !== 2'd2) begin bad++; $display("FAIL blank_grant_src: got %0d want 2", disp_src); end
        req_valid = '0;
        t = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (disp_blank) begin
                t = i;
                break;
            end
        end
        total++; if (t !== HOLD + BLANK) begin bad++; $display("FAIL blank_at: got %0d want %0d", t, HOLD + BLANK); end
        total++; if (disp_num !== 16'h5A5A) begin bad++; $display("FAIL blank_keep_num: got %h want 5A5A", disp_num); end
        data[0]   = 16'h7777;
        req_valid = 4'b0001;
        tick();
        total++; if (disp_blank !== 1'b0) begin bad++; $display("FAIL unblank: got %b want 0", disp_blank); end
        total++; if (disp_num !== 16'h7777) begin bad++; $display("FAIL unblank_num: got %h want 7777", disp_num); end
        total++; if (disp_src !== 2'd0) begin bad++; $display("FAIL unblank_src: got %0d want 0", disp_src); end
        req_valid = '0;
    endtask

    task automatic test_async_reset();
        repeat (4) tick();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL ar_pre_busy: got %b want 1", busy); end
        #2;
        rst = 1'b1;
        #1;
        total++; if (disp_num !== 16'h0000) begin bad++; $display("FAIL ar_num: got %h want 0000", disp_num); end
        total++; if (disp_blank !== 1'b1) begin bad++; $display("FAIL ar_blank: got %b want 1", disp_blank); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL ar_busy: got %b want 0", busy); end
        total++; if (disp_src !== 2'd0) begin bad++; $display("FAIL ar_src: got %0d want 0", disp_src); end
        data[0]   = 16'hBEEF;
        data[3]   = 16'h3EEE;
        req_valid = 4'b1001;
        tick();
        total++; if (req_ack !== 4'b0000) begin bad++; $display("FAIL ar_held_ack: got %b want 0000", req_ack); end
        rst = 1'b0;
        tick();
        total++; if (req_ack !== 4'b0001) begin bad++; $display("FAIL ar_regrant_ack: got %b want 0001", req_ack); end
        total++; if (disp_num !== 16'hBEEF) begin bad++; $display("FAIL ar_regrant_num: got %h want BEEF", disp_num); end
        req_valid = '0;
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        for (int i = 0; i < N; i++) data[i] = 16'h0000;
        repeat (2) tick();
        test_reset();
        rst = 1'b0;
        tick();
        test_grant_hold();
        test_pending_in_hold();
        test_round_robin();
        test_owner_refresh();
        test_blank();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
